// File: rtl/shift194_seq.sv
// Command sequencer for a 4-bit universal shift register: parallel load, then COUNT shifts.
// Ports: CLK, CLR_L, START, DIR, SIN, DIN, COUNT in; S1/S0, A-D, RIN/LIN, BUSY, DONE, MIRROR out.
module shift194_seq #(
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             CLR_L,
  input  logic             START,
  input  logic             DIR,
  input  logic             SIN,
  input  logic [3:0]       DIN,
  input  logic [CNT_W-1:0] COUNT,
  output logic             S1,
  output logic             S0,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  output logic             RIN,
  output logic             LIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [3:0]       MIRROR
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    FIN
  } state_e;

  state_e state_q, state_d;

  logic [3:0]       din_q, din_d;
  logic             dir_q, dir_d;
  logic             sin_q, sin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mir_q, mir_d;

  logic [1:0] s_q, s_d;
  logic       rin_q, rin_d;
  logic       lin_q, lin_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // State register
  always_ff @(posedge CLK) begin
    if (!CLR_L) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (START) state_d = LOAD;
      LOAD:    state_d = (cnt_q != '0) ? SHIFT : FIN;
      // Last shift edge is the one that takes the counter from 1 to 0
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, shift counter and shadow copy of the register
  always_comb begin
    din_d = din_q;
    dir_d = dir_q;
    sin_d = sin_q;
    cnt_d = cnt_q;
    mir_d = mir_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          din_d = DIN;
          dir_d = DIR;
          sin_d = SIN;
          cnt_d = COUNT;
        end
      end
      LOAD: mir_d = din_q;
      SHIFT: begin
        mir_d = dir_q ? {sin_q, mir_q[3:1]}
                      : {mir_q[2:0], sin_q};
        cnt_d = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CLR_L) begin
      din_q <= '0;
      dir_q <= 1'b0;
      sin_q <= 1'b0;
      cnt_q <= '0;
      mir_q <= '0;
    end else begin
      din_q <= din_d;
      dir_q <= dir_d;
      sin_q <= sin_d;
      cnt_q <= cnt_d;
      mir_q <= mir_d;
    end
  end

  // Outputs are decoded from the upcoming state and registered,
  // so every output is a flop with no path from the inputs.
  always_comb begin
    s_d    = 2'b00;
    rin_d  = 1'b0;
    lin_d  = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      IDLE: ;
      LOAD: begin
        s_d    = 2'b11;
        busy_d = 1'b1;
      end
      SHIFT: begin
        s_d    = dir_d ? 2'b01 : 2'b10;
        rin_d  = dir_d & sin_d;
        lin_d  = ~dir_d & sin_d;
        busy_d = 1'b1;
      end
      FIN: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CLR_L) begin
      s_q    <= 2'b00;
      rin_q  <= 1'b0;
      lin_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      rin_q  <= rin_d;
      lin_q  <= lin_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign S1     = s_q[1];
  assign S0     = s_q[0];
  // Parallel lines keep the last latched word; ignored unless S=11
  assign A      = din_q[3];
  assign B      = din_q[2];
  assign C      = din_q[1];
  assign D      = din_q[0];
  assign RIN    = rin_q;
  assign LIN    = lin_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign MIRROR = mir_q;

endmodule

// File: tb/tb_shift194_seq.sv
// Directed testbench for shift194_seq.
// Observes {S1,S0,A,B,C,D,RIN,LIN,BUSY,DONE,MIRROR} each cycle at the falling edge.
module tb_shift194_seq;

  logic       CLK;
  logic       CLR_L;
  logic       START;
  logic       DIR;
  logic       SIN;
  logic [3:0] DIN;
  logic [2:0] COUNT;
  logic       S1, S0, A, B, C, D;
  logic       RIN, LIN, BUSY, DONE;
  logic [3:0] MIRROR;

  int n_chk;
  int n_pass;

  shift194_seq #(.CNT_W(3)) dut (
    .CLK    (CLK),
    .CLR_L  (CLR_L),
    .START  (START),
    .DIR    (DIR),
    .SIN    (SIN),
    .DIN    (DIN),
    .COUNT  (COUNT),
    .S1     (S1),
    .S0     (S0),
    .A      (A),
    .B      (B),
    .C      (C),
    .D      (D),
    .RIN    (RIN),
    .LIN    (LIN),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .MIRROR (MIRROR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [13:0] obs,
                     input logic [13:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", tag, obs, exp);
  endtask

  // Wait one clock (falling edge to falling edge) and check the outputs
  task automatic cyc(input string tag, input logic [13:0] exp);
    @(negedge CLK);
    chk(tag, {S1, S0, A, B, C, D, RIN, LIN, BUSY, DONE, MIRROR}, exp);
  endtask

  task automatic issue(input logic [3:0] din, input logic dir,
                       input logic sin, input logic [2:0] cnt);
    START = 1'b1;
    DIN   = din;
    DIR   = dir;
    SIN   = sin;
    COUNT = cnt;
  endtask

  logic [3:0] max_mir [7];

  initial begin
    n_chk  = 0;
    n_pass = 0;
    max_mir = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                4'b1111, 4'b1111, 4'b1111};
    CLR_L = 1'b0;
    START = 1'b0;
    DIR   = 1'b0;
    SIN   = 1'b0;
    DIN   = 4'b0000;
    COUNT = 3'd0;

    // Reset state
    cyc("rst0", 14'b00_0000_00_00_0000);
    cyc("rst1", 14'b00_0000_00_00_0000);
    CLR_L = 1'b1;
    cyc("idle", 14'b00_0000_00_00_0000);

    // Load only
    issue(4'b1011, 1'b1, 1'b0, 3'd0);
    cyc("ld_load", 14'b11_1011_00_10_0000);
    START = 1'b0;
    cyc("ld_fin",  14'b00_1011_00_11_1011);
    cyc("ld_idle", 14'b00_1011_00_00_1011);

    // Right shift, zero fill
    issue(4'b1001, 1'b1, 1'b0, 3'd2);
    cyc("r_load", 14'b11_1001_00_10_1011);
    START = 1'b0;
    cyc("r_sh1",  14'b01_1001_00_10_1001);
    cyc("r_sh2",  14'b01_1001_00_10_0100);
    cyc("r_fin",  14'b00_1001_00_11_0010);
    cyc("r_idle", 14'b00_1001_00_00_0010);

    // Left shift with fill, START pulsed while busy
    issue(4'b0001, 1'b0, 1'b1, 3'd3);
    cyc("l_load", 14'b11_0001_00_10_0010);
    START = 1'b0;
    cyc("l_sh1",  14'b10_0001_01_10_0001);
    issue(4'b0110, 1'b1, 1'b0, 3'd5);
    cyc("l_sh2",  14'b10_0001_01_10_0011);
    START = 1'b0;
    cyc("l_sh3",  14'b10_0001_01_10_0111);
    cyc("l_fin",  14'b00_0001_00_11_1111);
    cyc("l_idle", 14'b00_0001_00_00_1111);

    // Back-to-back: START on the first IDLE cycle
    issue(4'b1100, 1'b1, 1'b1, 3'd1);
    cyc("b_load", 14'b11_1100_00_10_1111);
    START = 1'b0;
    cyc("b_sh1",  14'b01_1100_10_10_1100);
    cyc("b_fin",  14'b00_1100_00_11_1110);
    cyc("b_idle", 14'b00_1100_00_00_1110);

    // Max count
    issue(4'b0000, 1'b1, 1'b1, 3'd7);
    cyc("m_load", 14'b11_0000_00_10_1110);
    START = 1'b0;
    for (int i = 0; i < 7; i++)
      cyc($sformatf("m_sh%0d", i + 1), {10'b01_0000_10_10, max_mir[i]});
    cyc("m_fin",  14'b00_0000_00_11_1111);
    cyc("m_idle", 14'b00_0000_00_00_1111);

    // Reset during SHIFT aborts without DONE
    issue(4'b1010, 1'b0, 1'b0, 3'd5);
    cyc("a_load", 14'b11_1010_00_10_1111);
    START = 1'b0;
    cyc("a_sh1",  14'b10_1010_00_10_1010);
    CLR_L = 1'b0;
    cyc("a_rst0", 14'b00_0000_00_00_0000);
    cyc("a_rst1", 14'b00_0000_00_00_0000);
    CLR_L = 1'b1;
    for (int i = 0; i < 6; i++)
      cyc($sformatf("a_post%0d", i), 14'b00_0000_00_00_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
